i2c_s_if: RTL

- I2C slave (target) receiver for write transfers, the far end of the team's I2C master write interface.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit own address, ACKs address and data bytes.
- Collects up to 4 data bytes and presents them as one 32-bit word with a one-cycle valid pulse.
- Sits between the board-level open-drain pad logic and the register/command logic.

---
 rtl/i2c_pkg.sv | 41 ++++
 rtl/i2c_sync_edge.sv | 24 ++
 rtl/i2c_s_if.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave receiver states, bus levels and the bit time
// used by the matching master write interface.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_A_ACK,
      ST_DATA,
      ST_D_ACK,
      ST_D_NACK,
      ST_IGNORE
   } state_e;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_START,
      EV_STOP
   } bus_ev_e;

   localparam logic SDA_ACK = 1'b0;
   localparam logic SDA_REL = 1'b1;

   localparam int unsigned I2C_BIT_CLKS = 125;

   // First received byte lands in the most significant lane.
   function automatic logic [31:0] put_lane(input logic [31:0] word,
                                            input logic [1:0]  idx,
                                            input logic [7:0]  data);
      logic [31:0] res;
      res = word;
      case (idx)
         2'd0:    res[31:24] = data;
         2'd1:    res[23:16] = data;
         2'd2:    res[15:8]  = data;
         default: res[7:0]   = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad input, plus a third delayed
// copy that yields single-cycle rise/fall pulses on the synchronized value.
module i2c_sync_edge (
   input  logic clk_i,
   input  logic rstb_i,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [2:0] sh_q;

   // Preset high so an idle bus produces no edges when reset is released.
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) sh_q <= '1;
      else         sh_q <= {sh_q[1:0], d_i};
   end

   assign sync_o = sh_q[1];
   assign rise_o = sh_q[1] & ~sh_q[2];
   assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/i2c_s_if.sv
// I2C slave write receiver: matches a 7-bit address, ACKs up to P_MAX_BYTES
// data bytes and hands them over as one 32-bit word on STOP or repeated START.
module i2c_s_if
   import i2c_pkg::*;
#(
   parameter logic [11:0] P_HOLD_CNT  = 12'd10,
   parameter logic [2:0]  P_MAX_BYTES = 3'd4
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_o,
   input  logic [6:0]  own_adr,
   output logic [31:0] rx_data,
   output logic [2:0]  rx_bytes,
   output logic        rx_valid,
   output logic        busy
);

   logic scl_s, scl_rise, scl_fall;
   logic sda_s, sda_rise, sda_fall;

   i2c_sync_edge u_scl (
      .clk_i (clk),  .rstb_i(rstb), .d_i(scl_i),
      .sync_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   i2c_sync_edge u_sda (
      .clk_i (clk),  .rstb_i(rstb), .d_i(sda_i),
      .sync_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   state_e      state_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  shreg_q;
   logic [2:0]  byte_cnt_q;
   logic [31:0] data_q;
   logic        fall_seen_q;
   logic [11:0] hold_cnt_q;
   logic        sda_o_q;
   logic        busy_q;
   logic        rx_valid_q;
   logic [31:0] rx_data_q;
   logic [2:0]  rx_bytes_q;

   bus_ev_e     bus_ev_d;
   logic [7:0]  rx_byte_d;
   logic        hold_hit_d;

   always_comb begin
      bus_ev_d = EV_NONE;
      if (scl_s && sda_fall)      bus_ev_d = EV_START;
      else if (scl_s && sda_rise) bus_ev_d = EV_STOP;
   end

   assign rx_byte_d  = {shreg_q[6:0], sda_s};
   assign hold_hit_d = (hold_cnt_q == P_HOLD_CNT);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         byte_cnt_q  <= '0;
         data_q      <= '0;
         fall_seen_q <= 1'b0;
         hold_cnt_q  <= '0;
         sda_o_q     <= SDA_REL;
         busy_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= '0;
         rx_bytes_q  <= '0;
      end else begin
         rx_valid_q <= 1'b0;

         // Hold counter: 0 = idle, restarted by every SCL fall, hit at P_HOLD_CNT.
         if (scl_fall)               hold_cnt_q <= 12'd1;
         else if (hold_hit_d)        hold_cnt_q <= '0;
         else if (hold_cnt_q != '0)  hold_cnt_q <= hold_cnt_q + 12'd1;

         if (bus_ev_d != EV_NONE) begin
            if (busy_q && byte_cnt_q != '0) begin
               rx_data_q  <= data_q;
               rx_bytes_q <= byte_cnt_q;
               rx_valid_q <= 1'b1;
            end
            busy_q      <= 1'b0;
            sda_o_q     <= SDA_REL;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            data_q      <= '0;
            fall_seen_q <= 1'b0;
            state_q     <= (bus_ev_d == EV_START) ? ST_ADDR : ST_IDLE;
         end else begin
            case (state_q)
               ST_ADDR: if (scl_rise) begin
                  shreg_q   <= rx_byte_d;
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (rx_byte_d[7:1] == own_adr && !rx_byte_d[0]) begin
                        state_q <= ST_A_ACK;
                        busy_q  <= 1'b1;
                     end else begin
                        state_q <= ST_IGNORE;
                     end
                  end
               end
               // First hold point (after 8th fall) drives ACK, second releases it.
               ST_A_ACK, ST_D_ACK: if (hold_hit_d) begin
                  if (!fall_seen_q) begin
                     sda_o_q     <= SDA_ACK;
                     fall_seen_q <= 1'b1;
                  end else begin
                     sda_o_q     <= SDA_REL;
                     fall_seen_q <= 1'b0;
                     state_q     <= ST_DATA;
                  end
               end
               ST_DATA: if (scl_rise) begin
                  shreg_q   <= rx_byte_d;
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (byte_cnt_q < P_MAX_BYTES) begin
                        data_q     <= put_lane(data_q, byte_cnt_q[1:0], rx_byte_d);
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        state_q    <= ST_D_ACK;
                     end else begin
                        state_q <= ST_D_NACK;
                     end
                  end
               end
               ST_D_NACK: if (scl_fall) begin
                  if (!fall_seen_q) begin
                     fall_seen_q <= 1'b1;
                  end else begin
                     fall_seen_q <= 1'b0;
                     state_q     <= ST_IGNORE;
                  end
               end
               ST_IDLE, ST_IGNORE: sda_o_q <= SDA_REL;
               default:            state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign sda_o    = sda_o_q;
   assign busy     = busy_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign rx_bytes = rx_bytes_q;

endmodule
